// File: rtl/ball_renderer.sv
// ---------------------------------------------------------------------------
// ball_renderer
//
// Bouncing-ball demo layer for a 640x480 VGA pipeline. A square ball moves
// diagonally inside a white border and bounces off it. The upstream timing
// generator supplies pixel coordinates, video_on and the syncs. This block
// registers one colour per pixel tick. It delays the syncs by the same amount
// so that they stay aligned with the colour.
//
// Parameters
//   BALL_SIZE   ball edge length in pixels
//   BALL_STEP   per-frame displacement on each axis in pixels
//   WALL_WIDTH  border thickness in pixels
//   BALL_COLOR / WALL_COLOR / BG_COLOR   4:4:4 RGB colours
//
// Ports
//   clock_at_100mhz   system clock
//   reset_button_n    asynchronous active-low reset
//   p_tick            25 MHz pixel enable (one clock in four)
//   video_on          current pixel lies in the visible 640x480 area
//   x_pixel, y_pixel  current pixel coordinates (0-799, 0-524)
//   horizontal_sync, vertical_sync   upstream syncs
//   pause_button      (only with BALL_PAUSE_EN) freeze ball motion
//   rgb               registered pixel colour
//   hsync_out, vsync_out  syncs delayed to line up with rgb
//   frame_tick        one-clock pulse when pixel (0,480) is ticked
//   ball_x, ball_y    top-left corner of the ball
//   bounce_count      saturating count of wall bounces
//
// Optional feature: define BALL_PAUSE_EN to add pause_button and the PAUSED
// state.
// ---------------------------------------------------------------------------
module ball_renderer #(
    parameter int          BALL_SIZE  = 8,
    parameter int          BALL_STEP  = 2,
    parameter int          WALL_WIDTH = 4,
    parameter logic [11:0] BALL_COLOR = 12'hF00,
    parameter logic [11:0] WALL_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic        clock_at_100mhz,
    input  logic        reset_button_n,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    input  logic        horizontal_sync,
    input  logic        vertical_sync,
`ifdef BALL_PAUSE_EN
    input  logic        pause_button,
`endif
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_tick,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [7:0]  bounce_count
);

    // Movement limits for the ball's top-left corner. All position
    // arithmetic is done in 11 bits, so that +step near 1023 and -step near
    // 0 cannot wrap.
    localparam logic [10:0] STEP    = 11'(BALL_STEP);
    localparam logic [10:0] SIZE    = 11'(BALL_SIZE);
    localparam logic [10:0] WALL    = 11'(WALL_WIDTH);
    localparam logic [10:0] XMIN    = 11'(WALL_WIDTH);
    localparam logic [10:0] YMIN    = 11'(WALL_WIDTH);
    localparam logic [10:0] XMAX    = 11'(640 - WALL_WIDTH - BALL_SIZE);
    localparam logic [10:0] YMAX    = 11'(480 - WALL_WIDTH - BALL_SIZE);
    localparam logic [10:0] WALL_XR = 11'(640 - WALL_WIDTH);
    localparam logic [10:0] WALL_YB = 11'(480 - WALL_WIDTH);

    localparam logic [9:0]  X_RESET = 10'd316;
    localparam logic [9:0]  Y_RESET = 10'd236;

`ifdef BALL_PAUSE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    typedef struct packed {
        logic       bounced;
        logic       dir;
        logic [9:0] pos;
    } axis_t;

    state_t      state, state_next;
    logic        move_en;
    logic        dx, dy;
    axis_t       x_step, y_step;
    logic [7:0]  bounce_next;
    logic [8:0]  bounce_sum;
    logic [11:0] pixel_color;
    logic [10:0] px, py, bx, by;
    logic        in_ball, in_wall;

    // One axis of motion. The position moves by STEP in its direction. If
    // that would cross a limit, the position clamps to the limit and the
    // direction flips.
    function automatic axis_t axis_move(input logic [9:0] pos, input logic dir,
                                        input logic [10:0] lo, input logic [10:0] hi);
        axis_t       r;
        logic [10:0] p;
        logic [10:0] sum;
        logic [10:0] diff;
        p         = {1'b0, pos};
        sum       = p + STEP;
        diff      = p - STEP;
        r.bounced = 1'b0;
        r.dir     = dir;
        r.pos     = 10'(sum);
        if (dir) begin
            if (sum > hi) begin
                r.pos     = 10'(hi);
                r.dir     = 1'b0;
                r.bounced = 1'b1;
            end
        end else begin
            // p < lo + STEP is the same test as p - STEP < lo, without underflow
            if (p < lo + STEP) begin
                r.pos     = 10'(lo);
                r.dir     = 1'b1;
                r.bounced = 1'b1;
            end else begin
                r.pos     = 10'(diff);
            end
        end
        return r;
    endfunction

    // Frame boundary: the first blanking line, column 0. It is gated by reset,
    // so no frame can be acted on while reset is held.
    assign frame_tick = reset_button_n & p_tick & (x_pixel == 10'd0) & (y_pixel == 10'd480);

    // State register.
    always_ff @(posedge clock_at_100mhz or negedge reset_button_n) begin
        if (!reset_button_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The ball only moves on a frame tick in RUN that is
    // not entering a pause. The IDLE->RUN and PAUSED->RUN ticks leave it
    // where it is.
    always_comb begin
        state_next = state;
        move_en    = 1'b0;
        if (frame_tick) begin
            case (state)
                IDLE: state_next = RUN;
`ifdef BALL_PAUSE_EN
                RUN: begin
                    if (pause_button) begin
                        state_next = PAUSED;
                    end else begin
                        move_en = 1'b1;
                    end
                end
                PAUSED: begin
                    if (!pause_button) begin
                        state_next = RUN;
                    end
                end
`else
                RUN: move_en = 1'b1;
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    // Candidate next position and direction for both axes. The bounce total
    // adds one per axis that hit a wall, saturating at 255.
    always_comb begin
        x_step      = axis_move(ball_x, dx, XMIN, XMAX);
        y_step      = axis_move(ball_y, dy, YMIN, YMAX);
        bounce_sum  = {1'b0, bounce_count} + {8'd0, x_step.bounced} + {8'd0, y_step.bounced};
        bounce_next = (bounce_sum > 9'd255) ? 8'hFF : bounce_sum[7:0];
    end

    // Ball position, direction and bounce counter registers.
    always_ff @(posedge clock_at_100mhz or negedge reset_button_n) begin
        if (!reset_button_n) begin
            ball_x       <= X_RESET;
            ball_y       <= Y_RESET;
            dx           <= 1'b1;
            dy           <= 1'b1;
            bounce_count <= 8'd0;
        end else if (move_en) begin
            ball_x       <= x_step.pos;
            ball_y       <= y_step.pos;
            dx           <= x_step.dir;
            dy           <= y_step.dir;
            bounce_count <= bounce_next;
        end
    end

    // Pixel classification. The ball has priority over the wall, and the
    // wall has priority over the background. Blanking always gives black.
    always_comb begin
        px          = {1'b0, x_pixel};
        py          = {1'b0, y_pixel};
        bx          = {1'b0, ball_x};
        by          = {1'b0, ball_y};
        in_ball     = (px >= bx) && (px < bx + SIZE) && (py >= by) && (py < by + SIZE);
        in_wall     = (px < WALL) || (px >= WALL_XR) || (py < WALL) || (py >= WALL_YB);
        pixel_color = BG_COLOR;
        if (!video_on) begin
            pixel_color = 12'h000;
        end else if (in_ball) begin
            pixel_color = BALL_COLOR;
        end else if (in_wall) begin
            pixel_color = WALL_COLOR;
        end
    end

    // Output pipeline stage. It advances only on pixel ticks, so the syncs
    // keep the same one-tick latency as the colour.
    always_ff @(posedge clock_at_100mhz or negedge reset_button_n) begin
        if (!reset_button_n) begin
            rgb       <= 12'h000;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else if (p_tick) begin
            rgb       <= pixel_color;
            hsync_out <= horizontal_sync;
            vsync_out <= vertical_sync;
        end
    end

endmodule

// File: doc/ball_renderer.md
BALL_RENDERER -- requirements
Module: ball_renderer

Interface
REQ-001 The block SHALL provide parameter BALL_SIZE, default 8, meaning the ball edge length in pixels.
REQ-002 The block SHALL provide parameter BALL_STEP, default 2, meaning the per-frame displacement on each axis in pixels.
REQ-003 The block SHALL provide parameter WALL_WIDTH, default 4, meaning the border thickness in pixels.
REQ-004 The block SHALL provide parameters BALL_COLOR (default 12'hF00), WALL_COLOR (default 12'hFFF) and BG_COLOR (default 12'h000), each a 4:4:4 RGB value.
REQ-005 The block SHALL have clock_at_100mhz, input, 1 bit, the single system clock.
REQ-006 The block SHALL have reset_button_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have p_tick, input, 1 bit, the 25 MHz pixel enable, high for one clock in four.
REQ-008 The block SHALL have video_on, input, 1 bit, meaning the current pixel is in the active 640x480 area.
REQ-009 The block SHALL have x_pixel and y_pixel, inputs, 10 bits each, carrying the current pixel coordinates (0-799 horizontal, 0-524 vertical).
REQ-010 The block SHALL have horizontal_sync and vertical_sync, inputs, 1 bit each, the upstream sync signals.
REQ-011 The block SHALL have rgb, output, 12 bits, the pixel colour.
REQ-012 The block SHALL have hsync_out and vsync_out, outputs, 1 bit each, carrying the syncs aligned with rgb.
REQ-013 The block SHALL have frame_tick, output, 1 bit, a one-clock pulse once per frame.
REQ-014 The block SHALL have ball_x and ball_y, outputs, 10 bits each, giving the ball's top-left corner.
REQ-015 The block SHALL have bounce_count, output, 8 bits, a saturating count of wall bounces.

Function
REQ-016 frame_tick SHALL be 1 for exactly the clock in which p_tick=1, x_pixel=0 and y_pixel=480; it SHALL be 0 in every other clock.
REQ-017 The FSM SHALL have states IDLE and RUN (plus PAUSED, see Configuration); it SHALL enter IDLE at reset, go IDLE->RUN on the first frame_tick without moving the ball, and remain in RUN thereafter.
REQ-018 In RUN, ball_x and ball_y SHALL update only on frame_tick, each moving BALL_STEP in its own direction bit (dx, dy; 1 means +).
REQ-019 XMAX SHALL equal 640-WALL_WIDTH-BALL_SIZE (628 at defaults), XMIN SHALL equal WALL_WIDTH, YMAX SHALL equal 480-WALL_WIDTH-BALL_SIZE (468), and YMIN SHALL equal WALL_WIDTH.
REQ-020 When moving + and the position plus BALL_STEP would exceed the axis max, the position SHALL clamp to the max and the direction bit SHALL invert; the - direction SHALL behave symmetrically, with the position minus BALL_STEP falling below the axis min; all comparisons SHALL use 11-bit arithmetic with no wrap.
REQ-021 On each frame_tick, bounce_count SHALL increase by the number of axes that bounced (a corner hit adds 2) and SHALL saturate at 255.
REQ-022 On each p_tick, rgb SHALL register BALL_COLOR when the pixel is inside [ball_x, ball_x+BALL_SIZE) x [ball_y, ball_y+BALL_SIZE).
REQ-023 Otherwise, rgb SHALL register WALL_COLOR when x<WALL_WIDTH, x>=640-WALL_WIDTH, y<WALL_WIDTH or y>=480-WALL_WIDTH.
REQ-024 Otherwise, rgb SHALL register BG_COLOR; whenever video_on=0 it SHALL register 12'h000, overriding REQ-022 and REQ-023.
REQ-025 hsync_out and vsync_out SHALL register horizontal_sync and vertical_sync on the same p_tick, giving one-pixel-tick latency identical to rgb.
REQ-026 All outputs SHALL hold when p_tick=0.
REQ-027 Rendering SHALL use the ball position current at p_tick, and a position update occurring in the frame_tick clock SHALL take effect from the next pixel, which is in blanking.

Reset
REQ-028 While reset_button_n=0, the block SHALL immediately force rgb=0, hsync_out=0, vsync_out=0, frame_tick=0, ball_x=316, ball_y=236, dx=dy=1, bounce_count=0 and state IDLE, including mid-frame.
REQ-029 After reset release, the block SHALL act on no frame_tick earlier than the first one with reset high.

Configuration
REQ-030 When macro BALL_PAUSE_EN is defined, the block SHALL add input pause_button (1 bit) and state PAUSED: RUN->PAUSED on frame_tick with pause_button=1, PAUSED->RUN on frame_tick with pause_button=0, position and bounce_count frozen while PAUSED, and rendering continuing.
REQ-031 When BALL_PAUSE_EN is undefined, the block SHALL have no pause_button port and no PAUSED state.

Verification
REQ-032 The bench SHALL check that asserting reset_button_n=0 mid-line forces rgb=0, ball=(316,236) and bounce_count=0 within the same clock.
REQ-033 The bench SHALL check that with p_tick and video_on at pixel (320,240), rgb=12'hF00 the next clock; at (0,0) rgb=12'hFFF; at (100,100) rgb=12'h000; and with video_on=0 rgb=12'h000.
REQ-034 The bench SHALL check that after reset, frame 1 (IDLE->RUN) leaves the ball at (316,236) and frame 2 moves it to (318,238).
REQ-035 The bench SHALL check that 117 RUN frame_ticks give ball_y=468, dy=0, bounce_count=1 and ball_x=550.
REQ-036 The bench SHALL check that 156 RUN frames give ball_x=628, and the next frame keeps ball_x=628, sets dx=0 and increments bounce_count.
REQ-037 With BALL_PAUSE_EN defined, the bench SHALL check that holding pause_button=1 across 10 frame_ticks leaves ball_x, ball_y and bounce_count unchanged, and that motion resumes after the first frame_tick with pause_button=0.
